// File: rtl/chacha_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chacha_block_ctrl (plus combinational helper module round)
// Purpose  : Runs one ChaCha block function by iterating a single
//            combinational half-round instance over a captured 16-word state,
//            then adding the original state back in to form the keystream.
// Ports    : clock      - single clock, all updates on rising edge
//            reset_n    - asynchronous active-low reset
//            in_valid   - in_state carries a state to process
//            in_ready   - block can accept a state (IDLE only)
//            in_state   - 512-bit input, word i = in_state[32*i+:32]
//            out_valid  - out_state holds a finished keystream block
//            out_ready  - consumer accepts out_state
//            out_state  - 512-bit keystream block, same packing as in_state
//            busy       - high while a block is in flight (RUN/ADD/DONE)
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// round: one ChaCha half-round on four rows.
//   op_type = 0 : column half-round, lane j uses (a[j], b[j], c[j], d[j])
//   op_type = 1 : diagonal half-round, lane j uses
//                 (a[j], b[j+1], c[j+2], d[j+3]) with indices mod 4
// ----------------------------------------------------------------------------
module round (
  input  logic [127:0] input_a,
  input  logic [127:0] input_b,
  input  logic [127:0] input_c,
  input  logic [127:0] input_d,
  input  logic         op_type,
  output logic [127:0] output_a,
  output logic [127:0] output_b,
  output logic [127:0] output_c,
  output logic [127:0] output_d
);

  logic [3:0][31:0] w_qa;
  logic [3:0][31:0] w_qb;
  logic [3:0][31:0] w_qc;
  logic [3:0][31:0] w_qd;

  for (genvar j = 0; j < 4; j++) begin : g_lane
    localparam int c_JB = (j + 1) % 4;
    localparam int c_JC = (j + 2) % 4;
    localparam int c_JD = (j + 3) % 4;

    logic [31:0] w_a, w_b, w_c, w_d;
    logic [31:0] w_a1, w_b1, w_c1, w_d1;
    logic [31:0] w_a2, w_b2, w_c2, w_d2;
    logic [31:0] w_dx1, w_bx1, w_dx2, w_bx2;

    // Gather the lane operands; diagonal mode shifts rows b, c, d left.
    assign w_a = input_a[32*j+:32];
    assign w_b = op_type ? input_b[32*c_JB+:32] : input_b[32*j+:32];
    assign w_c = op_type ? input_c[32*c_JC+:32] : input_c[32*j+:32];
    assign w_d = op_type ? input_d[32*c_JD+:32] : input_d[32*j+:32];

    // Quarter round: add, xor, rotate by 16, 12, 8, 7.
    assign w_a1  = w_a + w_b;
    assign w_dx1 = w_d ^ w_a1;
    assign w_d1  = {w_dx1[15:0], w_dx1[31:16]};
    assign w_c1  = w_c + w_d1;
    assign w_bx1 = w_b ^ w_c1;
    assign w_b1  = {w_bx1[19:0], w_bx1[31:20]};
    assign w_a2  = w_a1 + w_b1;
    assign w_dx2 = w_d1 ^ w_a2;
    assign w_d2  = {w_dx2[23:0], w_dx2[31:24]};
    assign w_c2  = w_c1 + w_d2;
    assign w_bx2 = w_b1 ^ w_c2;
    assign w_b2  = {w_bx2[24:0], w_bx2[31:25]};

    assign w_qa[j] = w_a2;
    assign w_qb[j] = w_b2;
    assign w_qc[j] = w_c2;
    assign w_qd[j] = w_d2;
  end

  // Scatter lane results back to their home word positions (inverse shift).
  for (genvar k = 0; k < 4; k++) begin : g_scatter
    assign output_a[32*k+:32] = w_qa[k];
    assign output_b[32*k+:32] = op_type ? w_qb[(k+3)%4] : w_qb[k];
    assign output_c[32*k+:32] = op_type ? w_qc[(k+2)%4] : w_qc[k];
    assign output_d[32*k+:32] = op_type ? w_qd[(k+1)%4] : w_qd[k];
  end

endmodule

// ----------------------------------------------------------------------------
// chacha_block_ctrl: block sequencer. ROUNDS counts half-rounds and must be
// even and at least 2 (20 = ChaCha20, 8 = ChaCha8).
// ----------------------------------------------------------------------------
module chacha_block_ctrl #(
  parameter int ROUNDS = 20
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state,
  output logic         busy
);

  localparam int             c_CNT_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [511:0]         r_work;
  logic [511:0]         r_init;
  logic [511:0]         r_out_state;
  logic [c_CNT_W-1:0]   r_cnt;

  logic [511:0]         w_round_out;
  logic [511:0]         w_sum;
  logic                 w_accept;
  logic                 w_last;

  // --------------------------------------------------------------------------
  // Half-round datapath; the low counter bit alternates column / diagonal.
  // --------------------------------------------------------------------------
  round u_round (
    .input_a  (r_work[127:0]),
    .input_b  (r_work[255:128]),
    .input_c  (r_work[383:256]),
    .input_d  (r_work[511:384]),
    .op_type  (r_cnt[0]),
    .output_a (w_round_out[127:0]),
    .output_b (w_round_out[255:128]),
    .output_c (w_round_out[383:256]),
    .output_d (w_round_out[511:384])
  );

  // Final feed-forward: independent 32-bit adds, no carry between words.
  for (genvar i = 0; i < 16; i++) begin : g_add
    assign w_sum[32*i+:32] = r_work[32*i+:32] + r_init[32*i+:32];
  end

  assign w_last = (r_cnt == c_LAST_CNT);

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and outputs. In DONE only out_ready is honoured; a pending
  // in_valid is picked up in the following IDLE cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_next_state = ST_ADD;
        end
      end
      ST_ADD: begin
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_work      <= '0;
      r_init      <= '0;
      r_out_state <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        r_work <= in_state;
        r_init <= in_state;
        r_cnt  <= '0;
      end else if (r_state == ST_RUN) begin
        r_work <= w_round_out;
        // Saturate at the last index so the counter never wraps.
        if (!w_last) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (r_state == ST_ADD) begin
        r_out_state <= w_sum;
      end
    end
  end

  assign out_state = r_out_state;

endmodule
`default_nettype wire

// File: tb/tb_chacha_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chacha_block_ctrl
// Purpose  : Self-checking bench for chacha_block_ctrl (ROUNDS=20 and 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chacha_block_ctrl;

  logic         clock = 1'b0;
  logic         reset_n;
  always #5 clock = ~clock;

  // ROUNDS = 20 instance
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [511:0] in_state, out_state;
  // ROUNDS = 8 instance
  logic         v8_in_valid, v8_in_ready, v8_out_valid, v8_out_ready, v8_busy;
  logic [511:0] v8_in_state, v8_out_state;

  chacha_block_ctrl #(.ROUNDS(20)) dut20 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .busy(busy));

  chacha_block_ctrl #(.ROUNDS(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready),
    .in_state(v8_in_state), .out_valid(v8_out_valid), .out_ready(v8_out_ready),
    .out_state(v8_out_state), .busy(v8_busy));

  int checks   = 0;
  int failures = 0;
  logic [511:0] sb[$];

  logic [31:0] v1w [16] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                            32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                            32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                            32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
  logic [31:0] e1w [16] = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                            32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                            32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                            32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
  logic [511:0] v1, e1;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Reference ChaCha block: 'rounds' half-rounds, then add the input.
  function automatic logic [511:0] chacha_ref(input logic [511:0] s, input int rounds);
    logic [31:0] x [16];
    logic [511:0] r;
    int idx [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                       '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    for (int i = 0; i < 16; i++) x[i] = s[32*i+:32];
    for (int h = 0; h < rounds; h++) begin
      for (int q = 0; q < 4; q++) begin
        int qi = (h % 2) * 4 + q;
        logic [31:0] a, b, c, d;
        a = x[idx[qi][0]]; b = x[idx[qi][1]]; c = x[idx[qi][2]]; d = x[idx[qi][3]];
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        x[idx[qi][0]] = a; x[idx[qi][1]] = b; x[idx[qi][2]] = c; x[idx[qi][3]] = d;
      end
    end
    for (int i = 0; i < 16; i++) r[32*i+:32] = x[i] + s[32*i+:32];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_chk(input string tag, input logic [511:0] obs);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 512'(sb.size()), 512'd1);
    end else begin
      chk(tag, obs, sb.pop_front());
    end
  endtask

  // Sends one state to the ROUNDS=20 instance and waits until DONE.
  task automatic run20(input string tag, input logic [511:0] st, input logic [511:0] exp);
    int   n;
    logic busy_ok;
    in_state  = st;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    chk({tag, "_in_ready"}, 512'(in_ready), 512'd1);
    tick();                               // accept edge
    sb.push_back(exp);
    in_valid = 1'b0;
    in_state = ~st;                       // must not disturb the running block
    n = 0;
    busy_ok = 1'b1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
      if (!busy) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, 512'(n), 512'd21);
    chk({tag, "_busy"}, 512'(busy_ok), 512'd1);
    pop_chk({tag, "_out"}, out_state);
  endtask

  initial begin
    logic [511:0] held;
    logic         stable, acc;
    int           t, acc_cnt, outs, n;
    int           t_acc [2];

    for (int i = 0; i < 16; i++) begin
      v1[32*i+:32] = v1w[i];
      e1[32*i+:32] = e1w[i];
    end
    reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    v8_in_valid = 1'b0; v8_out_ready = 1'b0; v8_in_state = '0;
    tick(); tick();

    // Reset state
    chk("rst_in_ready", 512'(in_ready), 512'd1);
    chk("rst_out_valid", 512'(out_valid), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_out_state", out_state, '0);
    reset_n = 1'b1;
    tick();

    // RFC 8439 vector, then hold DONE with out_ready low
    run20("rfc", v1, e1);
    held   = out_state;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_state = '1;
      tick();
      if (!out_valid || in_ready || out_state !== held) stable = 1'b0;
    end
    chk("hold_stable", 512'(stable), 512'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("release_in_ready", 512'(in_ready), 512'd1);
    chk("release_out_valid", 512'(out_valid), 512'd0);
    chk("release_busy", 512'(busy), 512'd0);
    chk("release_out_kept", out_state, e1);
    out_ready = 1'b0;

    // All-zero state
    run20("zero", '0, '0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset at cnt = 7
    in_state = v1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 512'(out_valid), 512'd0);
    chk("arst_in_ready", 512'(in_ready), 512'd1);
    chk("arst_busy", 512'(busy), 512'd0);
    chk("arst_out_state", out_state, '0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();
    run20("resend", v1, e1);
    out_ready = 1'b1;
    tick();

    // Back-to-back vectors with out_ready tied high
    in_state = v1;
    in_valid = 1'b1;
    t = 0; acc_cnt = 0; outs = 0;
    t_acc[0] = 0; t_acc[1] = 0;
    while (outs < 2 && t < 200) begin
      acc = in_valid && in_ready;
      tick();
      t++;
      if (acc) begin
        t_acc[acc_cnt] = t;
        sb.push_back(acc_cnt == 0 ? e1 : 512'd0);
        acc_cnt++;
        if (acc_cnt == 1) in_state = '0;
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        pop_chk(outs == 0 ? "b2b_first" : "b2b_second", out_state);
        outs++;
      end
    end
    chk("b2b_outputs", 512'(outs), 512'd2);
    chk("b2b_spacing", 512'(t_acc[1] - t_acc[0]), 512'd23);
    out_ready = 1'b0;
    in_valid  = 1'b0;

    // ChaCha8 on the second instance
    v8_in_state = v1;
    v8_in_valid = 1'b1;
    chk("c8_in_ready", 512'(v8_in_ready), 512'd1);
    tick();
    sb.push_back(chacha_ref(v1, 8));
    v8_in_valid = 1'b0;
    n = 0;
    while (!v8_out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("c8_latency", 512'(n), 512'd9);
    pop_chk("c8_out", v8_out_state);
    v8_out_ready = 1'b1;
    tick();
    chk("c8_release", 512'(v8_out_valid), 512'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
